// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice allocator sitting between the MIDI parser and the per-voice
// synthesis pipelines. Note-ons go to the oldest free voice; when every voice
// is busy the oldest voice is stolen (OFF then ON, over two cycles). Repeated
// note numbers retrigger their voice. Note-offs received while the sustain
// pedal is down mark the voice as held; when the pedal lifts a sweep releases
// every held voice, one voice index per cycle.
//
// Ports:
//   clock_50_000_000  in   system clock
//   reset_l           in   asynchronous active-low reset
//   note              in   note event (status, note_number, velocity)
//   note_ready        in   note is valid, held stable until accepted
//   note_accept       out  allocator can take an event this cycle
//   sustain           in   sustain pedal level (1 = held)
//   voice_notes       out  current state of every voice
//   voice_notes_ready out  one-cycle pulse per voice when its entry changes
//   voices_active     out  number of voices whose status is ON
// -----------------------------------------------------------------------------
package voice_allocator_pkg;
    localparam logic NOTE_OFF = 1'b0;
    localparam logic NOTE_ON  = 1'b1;

    typedef struct packed {
        logic       status;
        logic [6:0] note_number;
        logic [6:0] velocity;
    } note_change_t;
endpackage

module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICE_COUNT = 8
) (
    input  logic                                 clock_50_000_000,
    input  logic                                 reset_l,
    input  note_change_t                         note,
    input  logic                                 note_ready,
    output logic                                 note_accept,
    input  logic                                 sustain,
    output note_change_t [VOICE_COUNT-1:0]       voice_notes,
    output logic [VOICE_COUNT-1:0]               voice_notes_ready,
    output logic [$clog2(VOICE_COUNT+1)-1:0]     voices_active
);

    localparam int RW = $clog2(VOICE_COUNT);
    localparam int AW = $clog2(VOICE_COUNT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STEAL   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    // Voice state
    logic [VOICE_COUNT-1:0] r_status, r_held, r_ready;
    logic [6:0]             r_num  [VOICE_COUNT];
    logic [6:0]             r_vel  [VOICE_COUNT];
    logic [RW-1:0]          r_rank [VOICE_COUNT];

    // Control state
    logic [1:0]    r_state;
    logic          r_accept;
    logic          r_sus_d;
    logic          r_release_pending;
    logic [RW-1:0] r_idx;
    logic [RW-1:0] r_steal_idx;
    logic [6:0]    r_lat_num, r_lat_vel;
    logic [AW-1:0] r_active;

    // Next-state values
    logic [VOICE_COUNT-1:0] w_status_next, w_held_next, w_ready_next;
    logic [6:0]             w_num_next  [VOICE_COUNT];
    logic [6:0]             w_vel_next  [VOICE_COUNT];
    logic [RW-1:0]          w_rank_next [VOICE_COUNT];
    logic [1:0]             w_state_next;
    logic                   w_accept_next;
    logic                   w_pending_next;
    logic [RW-1:0]          w_idx_next, w_steal_idx_next;
    logic [6:0]             w_lat_num_next, w_lat_vel_next;
    logic [AW-1:0]          w_active_next;

    // Search results
    logic          w_match_hit, w_free_hit;
    logic [RW-1:0] w_match_idx, w_free_idx, w_free_rank, w_old_idx;
    logic          w_touch_en;
    logic [RW-1:0] w_touch_idx;
    logic          w_fire, w_fall, w_pend_eff;

    assign w_fire = note_ready && r_accept;
    assign w_fall = r_sus_d && !sustain;
    // A fall seen this cycle counts as pending already, so an idle allocator
    // starts the sweep on the very edge that detects the fall.
    assign w_pend_eff = r_release_pending || w_fall;

    // Voice lookups: matching ON voice (lowest index), oldest OFF voice and
    // the overall oldest voice (rank VOICE_COUNT-1).
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
            if (r_status[i] && (r_num[i] == note.note_number)) begin
                w_match_hit = 1'b1;
                w_match_idx = RW'(i);
            end
        end

        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        w_free_rank = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (!r_status[i] && (!w_free_hit || (r_rank[i] > w_free_rank))) begin
                w_free_hit  = 1'b1;
                w_free_idx  = RW'(i);
                w_free_rank = r_rank[i];
            end
        end

        w_old_idx = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (r_rank[i] == RW'(VOICE_COUNT - 1)) begin
                w_old_idx = RW'(i);
            end
        end
    end

    always_comb begin
        w_status_next    = r_status;
        w_held_next      = r_held;
        w_ready_next     = '0;
        w_num_next       = r_num;
        w_vel_next       = r_vel;
        w_state_next     = r_state;
        w_pending_next   = w_pend_eff;
        w_idx_next       = r_idx;
        w_steal_idx_next = r_steal_idx;
        w_lat_num_next   = r_lat_num;
        w_lat_vel_next   = r_lat_vel;
        w_touch_en       = 1'b0;
        w_touch_idx      = '0;

        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (note.status == NOTE_ON) begin
                        if (w_match_hit) begin
                            // Retrigger: same voice, fresh velocity
                            w_vel_next[w_match_idx]   = note.velocity;
                            w_held_next[w_match_idx]  = 1'b0;
                            w_ready_next[w_match_idx] = 1'b1;
                            w_touch_en  = 1'b1;
                            w_touch_idx = w_match_idx;
                        end else if (w_free_hit) begin
                            w_status_next[w_free_idx] = NOTE_ON;
                            w_num_next[w_free_idx]    = note.note_number;
                            w_vel_next[w_free_idx]    = note.velocity;
                            w_held_next[w_free_idx]   = 1'b0;
                            w_ready_next[w_free_idx]  = 1'b1;
                            w_touch_en  = 1'b1;
                            w_touch_idx = w_free_idx;
                        end else begin
                            // Steal: silence the oldest voice now, restart it
                            // with the latched event in STEAL.
                            w_status_next[w_old_idx] = NOTE_OFF;
                            w_held_next[w_old_idx]   = 1'b0;
                            w_ready_next[w_old_idx]  = 1'b1;
                            w_steal_idx_next = w_old_idx;
                            w_lat_num_next   = note.note_number;
                            w_lat_vel_next   = note.velocity;
                            w_state_next     = S_STEAL;
                        end
                    end else if (w_match_hit && !r_held[w_match_idx]) begin
                        if (sustain) begin
                            w_held_next[w_match_idx] = 1'b1;
                        end else begin
                            w_status_next[w_match_idx] = NOTE_OFF;
                            w_ready_next[w_match_idx]  = 1'b1;
                        end
                    end
                end else if (w_pend_eff) begin
                    w_state_next   = S_RELEASE;
                    w_pending_next = 1'b0;
                    w_idx_next     = '0;
                end
            end

            S_STEAL: begin
                w_status_next[r_steal_idx] = NOTE_ON;
                w_num_next[r_steal_idx]    = r_lat_num;
                w_vel_next[r_steal_idx]    = r_lat_vel;
                w_held_next[r_steal_idx]   = 1'b0;
                w_ready_next[r_steal_idx]  = 1'b1;
                w_touch_en   = 1'b1;
                w_touch_idx  = r_steal_idx;
                w_state_next = S_IDLE;
            end

            S_RELEASE: begin
                if (r_held[r_idx]) begin
                    w_status_next[r_idx] = NOTE_OFF;
                    w_held_next[r_idx]   = 1'b0;
                    w_ready_next[r_idx]  = 1'b1;
                end
                if (r_idx == RW'(VOICE_COUNT - 1)) begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Touch: the touched voice becomes newest, younger voices age by one.
        w_rank_next = r_rank;
        if (w_touch_en) begin
            for (int j = 0; j < VOICE_COUNT; j++) begin
                if (RW'(j) == w_touch_idx) begin
                    w_rank_next[j] = '0;
                end else if (r_rank[j] < r_rank[w_touch_idx]) begin
                    w_rank_next[j] = r_rank[j] + 1'b1;
                end
            end
        end

        // Accept is closed while a pending release still has to start.
        w_accept_next = (w_state_next == S_IDLE) && !w_pending_next;

        w_active_next = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            w_active_next = w_active_next + AW'(w_status_next[i]);
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            r_status          <= '0;
            r_held            <= '0;
            r_ready           <= '0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                r_num[i]  <= '0;
                r_vel[i]  <= '0;
                r_rank[i] <= RW'(VOICE_COUNT - 1 - i);
            end
            r_state           <= S_IDLE;
            r_accept          <= 1'b1;
            r_sus_d           <= 1'b0;
            r_release_pending <= 1'b0;
            r_idx             <= '0;
            r_steal_idx       <= '0;
            r_lat_num         <= '0;
            r_lat_vel         <= '0;
            r_active          <= '0;
        end else begin
            r_status          <= w_status_next;
            r_held            <= w_held_next;
            r_ready           <= w_ready_next;
            r_num             <= w_num_next;
            r_vel             <= w_vel_next;
            r_rank            <= w_rank_next;
            r_state           <= w_state_next;
            r_accept          <= w_accept_next;
            r_sus_d           <= sustain;
            r_release_pending <= w_pending_next;
            r_idx             <= w_idx_next;
            r_steal_idx       <= w_steal_idx_next;
            r_lat_num         <= w_lat_num_next;
            r_lat_vel         <= w_lat_vel_next;
            r_active          <= w_active_next;
        end
    end

    generate
        for (genvar gi = 0; gi < VOICE_COUNT; gi++) begin : g_out
            assign voice_notes[gi] = '{status:      r_status[gi],
                                       note_number: r_num[gi],
                                       velocity:    r_vel[gi]};
        end
    endgenerate

    assign voice_notes_ready = r_ready;
    assign note_accept       = r_accept;
    assign voices_active     = r_active;

endmodule
